// File: rtl/i2c_apb_regif.sv
// APB3 register interface for the I2C master: CMD, STATUS and ADDR registers plus TX/RX byte FIFOs.
// Zero-wait-state slave; every side effect happens on the completing access-phase edge.
module i2c_apb_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          empty,
  output logic          full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign rdata = mem_q[rptr_q];

  always_comb begin
    pop_ok  = pop & ~empty;
    // a same-cycle pop frees a slot, so a push into a full FIFO still lands
    push_ok = push & (~full | pop_ok);
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (push_ok) begin
      mem_d[wptr_q] = wdata;
      wptr_d        = wptr_q + PW'(1);
    end
    if (pop_ok) rptr_d = rptr_q + PW'(1);
    cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q  <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

module i2c_apb_regif #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSELx,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic [DATA_WIDTH-1:0] cmd_reg,
  output logic [6:0]            slv_addr,
  output logic                  slv_rw,
  output logic                  start_pulse,
  input  logic                  tx_rd_en,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_empty,
  input  logic                  rx_wr_en,
  input  logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_full,
  input  logic                  core_busy,
  input  logic                  core_ack_err
);
  localparam logic [ADDR_WIDTH-1:0] A_CMD  = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_STAT = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_TX   = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] A_RX   = ADDR_WIDTH'(5);
  localparam logic [ADDR_WIDTH-1:0] A_ADDR = ADDR_WIDTH'(6);

  logic                  access, err, done;
  logic                  wr_cmd, wr_tx, rd_rx, wr_addr;
  logic                  tx_full, rx_empty;
  logic [DATA_WIDTH-1:0] rx_head, status;
  logic [DATA_WIDTH-1:0] cmd_reg_q, cmd_reg_d;
  logic [6:0]            slv_addr_q, slv_addr_d;
  logic                  slv_rw_q, slv_rw_d;
  logic                  start_pulse_q, start_pulse_d;
  logic                  ack_err_q, ack_err_d;

  // reset also masks the combinational APB outputs so an aborted transfer looks idle
  assign access = PSELx & PENABLE & ~PRESET;
  assign PREADY = access;
  assign status = DATA_WIDTH'({tx_full, tx_empty, rx_full, rx_empty, core_busy, ack_err_q, 2'b00});

  always_comb begin
    err    = 1'b0;
    PRDATA = '0;
    if (access) begin
      case (PADDR)
        A_CMD, A_ADDR: err = ~PWRITE;
        A_STAT: if (PWRITE) err = 1'b1; else PRDATA = status;
        A_TX:   err = ~PWRITE | tx_full;
        A_RX:   if (PWRITE | rx_empty) err = 1'b1; else PRDATA = rx_head;
        default: err = 1'b1;
      endcase
    end
  end

  assign PSLVERR = err;
  assign done    = access & ~err;
  assign wr_cmd  = done & (PADDR == A_CMD);
  assign wr_tx   = done & (PADDR == A_TX);
  assign rd_rx   = done & (PADDR == A_RX);
  assign wr_addr = done & (PADDR == A_ADDR);

  always_comb begin
    cmd_reg_d     = cmd_reg_q;
    slv_addr_d    = slv_addr_q;
    slv_rw_d      = slv_rw_q;
    start_pulse_d = 1'b0;
    ack_err_d     = ack_err_q;
    if (start_pulse_q) cmd_reg_d[0] = 1'b0;
    if (wr_cmd) begin
      cmd_reg_d     = PWDATA;
      start_pulse_d = PWDATA[0];
    end
    if (wr_addr) begin
      slv_addr_d = PWDATA[7:1];
      slv_rw_d   = PWDATA[0];
    end
    if (wr_cmd & PWDATA[1]) ack_err_d = 1'b0;
    if (core_ack_err)       ack_err_d = 1'b1;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cmd_reg_q     <= '0;
      slv_addr_q    <= '0;
      slv_rw_q      <= 1'b0;
      start_pulse_q <= 1'b0;
      ack_err_q     <= 1'b0;
    end else begin
      cmd_reg_q     <= cmd_reg_d;
      slv_addr_q    <= slv_addr_d;
      slv_rw_q      <= slv_rw_d;
      start_pulse_q <= start_pulse_d;
      ack_err_q     <= ack_err_d;
    end
  end

  assign cmd_reg     = cmd_reg_q;
  assign slv_addr    = slv_addr_q;
  assign slv_rw      = slv_rw_q;
  assign start_pulse = start_pulse_q;

  i2c_apb_fifo #(.DW(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(PCLK), .rst(PRESET), .push(wr_tx), .pop(tx_rd_en), .wdata(PWDATA),
    .rdata(tx_data), .empty(tx_empty), .full(tx_full)
  );

  i2c_apb_fifo #(.DW(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(PCLK), .rst(PRESET), .push(rx_wr_en), .pop(rd_rx), .wdata(rx_data),
    .rdata(rx_head), .empty(rx_empty), .full(rx_full)
  );
endmodule

// File: doc/i2c_apb_regif.md
Name: i2c_apb_regif

Overview:
APB3 slave register interface for the I2C master. It decodes APB accesses into the control register, slave-address register, TX data FIFO and RX data FIFO, and reports status. It sits between the APB bus `intf` (PCLK, PSELx, PENABLE, PWRITE, PADDR, PWDATA) and the I2C byte engine.

Parameters:
DATA_WIDTH, 8, width of PWDATA/PRDATA and FIFO entries.
ADDR_WIDTH, 8, width of PADDR.
FIFO_DEPTH, 8, entries per FIFO; power of two, at least 2.

Ports:
PCLK  in  1  single clock for the whole block.
PRESET  in  1  asynchronous, active-high reset.
PSELx  in  1  APB select.
PENABLE  in  1  APB access phase.
PWRITE  in  1  1 = write, 0 = read.
PADDR  in  ADDR_WIDTH  register address.
PWDATA  in  DATA_WIDTH  write data.
PRDATA  out  DATA_WIDTH  read data; valid in the access phase.
PREADY  out  1  transfer complete.
PSLVERR  out  1  error response; qualified by PREADY.
cmd_reg  out  DATA_WIDTH  control register to the engine.
slv_addr  out  7  target address.
slv_rw  out  1  1 = I2C read.
start_pulse  out  1  one-cycle start request.
tx_rd_en  in  1  engine pops TX FIFO.
tx_data  out  DATA_WIDTH  TX FIFO head (first-word fall-through).
tx_empty  out  1  TX FIFO empty.
rx_wr_en  in  1  engine pushes RX FIFO.
rx_data  in  DATA_WIDTH  byte received by the engine.
rx_full  out  1  RX FIFO full.
core_busy  in  1  engine transfer in progress.
core_ack_err  in  1  NACK seen; sticky in status.

Behaviour:
- Reset (PRESET=1, asynchronous) clears:
  - PRDATA=0, PSLVERR=0, PREADY=0, cmd_reg=0, slv_addr=0, slv_rw=0, start_pulse=0.
  - Both FIFOs emptied: tx_empty=1, rx_full=0.
  - ack_err sticky bit cleared.
  - Reset mid-transfer aborts it; no FIFO push or pop occurs.
- APB timing:
  - Setup phase is PSELx & !PENABLE. Access phase is PSELx & PENABLE.
  - No wait states: PREADY=1 in every access phase and 0 otherwise.
  - A transfer completes on the cycle where PSELx & PENABLE & PREADY.
  - All side effects (register writes, FIFO push/pop) occur on that completing edge only.
- Address map:
  - 2, write only: CMD. cmd_reg <= PWDATA. If PWDATA[0]=1, start_pulse=1 on the cycle after completion, for exactly 1 cycle. cmd_reg[0] then self-clears on that same cycle.
  - 3, read only: STATUS. Bit layout: [7] tx_full, [6] tx_empty, [5] rx_full, [4] rx_empty, [3] core_busy, [2] ack_err, [1:0] = 0.
  - 4, write only: TX_DATA. Pushes PWDATA into the TX FIFO.
  - 5, read only: RX_DATA. PRDATA = RX head; the head is popped on completion.
  - 6, write only: ADDR. slv_addr <= PWDATA[7:1], slv_rw <= PWDATA[0].
- PRDATA is combinational from the decoded address during the access phase and 0 otherwise.
- Errors: PSLVERR=1 during the access phase, with no side effect, for:
  - a write to 3 or 5;
  - a read of 2, 4 or 6;
  - any address outside 2..6;
  - a write to 4 while tx_full;
  - a read of 5 while rx_empty (PRDATA=0).
- ack_err:
  - Set on any cycle where core_ack_err=1.
  - Cleared by a completed write to CMD with PWDATA[1]=1.
  - If set and clear coincide, set wins.
- FIFOs:
  - Circular buffers with read/write pointers and an occupancy count of width clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
  - Full when count == FIFO_DEPTH; empty when count == 0.
  - tx_rd_en while tx_empty is ignored. rx_wr_en while rx_full drops the byte.
  - Simultaneous push and pop on a non-empty, non-full FIFO: count unchanged, data order preserved.
  - RX full, and an APB pop coincides with an engine push: both succeed.
  - TX empty, and an APB push coincides with an engine pop: the push succeeds, the pop is ignored.
- start_pulse is not gated by core_busy; the engine arbitrates.

Test Plan:
1. Reset, then read addr 3 -> PRDATA=8'h50 (tx_empty, rx_empty), PREADY=1 in the access phase, PSLVERR=0.
2. Write 8'hA1 to addr 6, then 8'h01 to addr 2 -> slv_addr=7'h50, slv_rw=1; start_pulse high for exactly one cycle after the access phase; cmd_reg[0] returns to 0.
3. Write 8 bytes 8'h10..8'h17 to addr 4 -> status bit7=1. A 9th write gets PSLVERR=1 and is dropped. Engine pops 8 times -> tx_data sequence 10..17, then tx_empty=1.
4. Engine pushes 8'h3C and 8'h5A, then APB reads addr 5 twice -> 3C, 5A with PSLVERR=0. A third read gets PRDATA=0, PSLVERR=1.
5. Read addr 2, write addr 3, access addr 9 -> PSLVERR=1 each time, with no state change.
6. Pulse core_ack_err -> status bit2=1. Write 8'h02 to addr 2 -> bit2=0. Assert PRESET mid access phase -> all outputs return to reset values immediately.
